// File: rtl/digital_tube_pkg.sv
// rtl/digital_tube_pkg.sv - register offsets and segment patterns for the digit tube scanner
package digital_tube_pkg;

    localparam logic [3:0] OFF_DATA0 = 4'h0;
    localparam logic [3:0] OFF_DATA1 = 4'h2;
    localparam logic [3:0] OFF_DATA2 = 4'h4;
    localparam logic [3:0] OFF_DATA3 = 4'h6;
    localparam logic [3:0] OFF_MASK  = 4'h8;
    localparam logic [3:0] OFF_DP    = 4'hA;
    localparam logic [3:0] OFF_BLINK = 4'hC;
    localparam logic [3:0] OFF_CTRL  = 4'hE;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low a..g, segment a in bit 6; entry 15 is the leftmost chunk.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
        7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - hex nibble to active-low seven-segment pattern
module seg7_decoder
    import digital_tube_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    assign segments = SEG_TABLE[nibble];

endmodule

// File: rtl/digital_tube_scanner.sv
// rtl/digital_tube_scanner.sv - memory-mapped multiplexed 7-segment scanner; blink via DIGITAL_TUBE_BLINK_EN
module digital_tube_scanner
    import digital_tube_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int CLK_DIV     = 26,
    parameter int BLINK_STEPS = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              digitalTubeCtrl,
    input  logic              write_enable,
    input  logic              read_enable,
    input  logic [3:0]        address,
    input  logic [15:0]       write_data_in,
    output logic [15:0]       read_data_out,
    output logic [DIGITS-1:0] enable,
    output logic [7:0]        value
);

    localparam int WORDS = DIGITS / 4;
    localparam int IDX_W = $clog2(DIGITS);

    logic [DIGITS*4-1:0] data_q;
    logic [DIGITS-1:0]   mask_q;
    logic [DIGITS-1:0]   dp_q;
    logic [DIGITS-1:0]   blink_q;
    logic                blank_q;
    logic                blink_off;

    logic [15:0]         presc_q;
    logic [IDX_W-1:0]    idx_q;
    logic                step;

    logic                wr;
    logic                rd;
    logic [2:0]          word;
    logic [15:0]         rd_word;
    logic                unused_addr_lsb;

    logic [3:0]          cur_nib;
    logic [6:0]          cur_seg;
    logic                lit;

    assign wr              = digitalTubeCtrl & write_enable;
    assign rd              = digitalTubeCtrl & read_enable;
    assign word            = address[3:1];
    assign unused_addr_lsb = address[0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            mask_q  <= '0;
            dp_q    <= '0;
            blank_q <= 1'b0;
        end else if (wr) begin
            for (int k = 0; k < WORDS; k++) begin
                if (word == 3'(k)) data_q[k*16 +: 16] <= write_data_in;
            end
            if (word == OFF_MASK[3:1]) mask_q  <= write_data_in[DIGITS-1:0];
            if (word == OFF_DP[3:1])   dp_q    <= write_data_in[DIGITS-1:0];
            if (word == OFF_CTRL[3:1]) blank_q <= write_data_in[0];
        end
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (word == 3'(k)) rd_word = data_q[k*16 +: 16];
        end
        if (word == OFF_MASK[3:1])  rd_word[DIGITS-1:0] = mask_q;
        if (word == OFF_DP[3:1])    rd_word[DIGITS-1:0] = dp_q;
        if (word == OFF_BLINK[3:1]) rd_word[DIGITS-1:0] = blink_q;
        if (word == OFF_CTRL[3:1])  rd_word[0]          = blank_q;
    end

    // Nonblocking load gives old-value semantics on a same-cycle read/write hit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)   read_data_out <= '0;
        else if (rd) read_data_out <= rd_word;
    end

    assign step = (presc_q == 16'(CLK_DIV - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= step ? '0 : presc_q + 16'd1;
            if (step) idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

`ifdef DIGITAL_TUBE_BLINK_EN
    logic [15:0] blink_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_q     <= '0;
            blink_cnt_q <= '0;
            blink_off   <= 1'b0;
        end else begin
            if (wr && word == OFF_BLINK[3:1]) blink_q <= write_data_in[DIGITS-1:0];
            if (step) begin
                if (blink_cnt_q == 16'(BLINK_STEPS - 1)) begin
                    blink_cnt_q <= '0;
                    blink_off   <= ~blink_off;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 16'd1;
                end
            end
        end
    end
`else
    assign blink_q   = '0;
    assign blink_off = 1'b0;
`endif

    assign cur_nib = data_q[idx_q*4 +: 4];

    seg7_decoder u_seg7_decoder (
        .nibble   (cur_nib),
        .segments (cur_seg)
    );

    assign lit = mask_q[idx_q] & ~blank_q & ~(blink_q[idx_q] & blink_off);

    // Outputs change only on step edges so a digit is always driven for a whole step.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enable <= '1;
            value  <= SEG_BLANK;
        end else if (step) begin
            if (lit) begin
                enable <= ~(DIGITS'(1) << idx_q);
                value  <= {cur_seg, ~dp_q[idx_q]};
            end else begin
                enable <= '1;
                value  <= SEG_BLANK;
            end
        end
    end

endmodule

// File: tb/tb_digital_tube_scanner.sv
// tb/tb_digital_tube_scanner.sv - randomized bench with a behavioural reference model for digital_tube_scanner
module tb_digital_tube_scanner;

    localparam int DIGITS      = 8;
    localparam int CLK_DIV     = 4;
    localparam int BLINK_STEPS = 3;
`ifdef DIGITAL_TUBE_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              digitalTubeCtrl = 1'b0;
    logic              write_enable = 1'b0;
    logic              read_enable = 1'b0;
    logic [3:0]        address = '0;
    logic [15:0]       write_data_in = '0;
    logic [15:0]       read_data_out;
    logic [DIGITS-1:0] enable;
    logic [7:0]        value;

    digital_tube_scanner #(
        .DIGITS      (DIGITS),
        .CLK_DIV     (CLK_DIV),
        .BLINK_STEPS (BLINK_STEPS)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .digitalTubeCtrl (digitalTubeCtrl),
        .write_enable    (write_enable),
        .read_enable     (read_enable),
        .address         (address),
        .write_data_in   (write_data_in),
        .read_data_out   (read_data_out),
        .enable          (enable),
        .value           (value)
    );

    always #5 clock = ~clock;

    logic [6:0] seg_ref [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic [3:0]        m_nib [DIGITS];
    logic [DIGITS-1:0] m_mask, m_dp, m_blink;
    logic              m_ctrl;
    int unsigned       m_cyc;
    logic [DIGITS-1:0] exp_en;
    logic [7:0]        exp_val;
    logic [15:0]       exp_rd;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DIGITS; i++) m_nib[i] = '0;
        m_mask  = '0;
        m_dp    = '0;
        m_blink = '0;
        m_ctrl  = 1'b0;
        m_cyc   = 0;
        exp_en  = '1;
        exp_val = 8'hFF;
        exp_rd  = '0;
    endtask

    function automatic logic [15:0] model_read(input int w);
        logic [15:0] r;
        r = '0;
        if (w < DIGITS / 4)
            for (int j = 0; j < 4; j++) r[4*j +: 4] = m_nib[4*w + j];
        else if (w == 4) r[DIGITS-1:0] = m_mask;
        else if (w == 5) r[DIGITS-1:0] = m_dp;
        else if (w == 6) r[DIGITS-1:0] = BLINK_EN ? m_blink : '0;
        else if (w == 7) r[0] = m_ctrl;
        return r;
    endfunction

    task automatic model_edge(input bit cs, input bit we, input bit re,
                              input logic [3:0] addr, input logic [15:0] wd);
        int n, idx, w;
        bit boff, lit;
        m_cyc++;
        if (m_cyc % CLK_DIV == 0) begin
            n    = int'(m_cyc / CLK_DIV) - 1;
            idx  = n % DIGITS;
            boff = BLINK_EN && (((n / BLINK_STEPS) % 2) == 1);
            lit  = m_mask[idx] && !m_ctrl && !(m_blink[idx] && boff);
            if (lit) begin
                exp_en      = '1;
                exp_en[idx] = 1'b0;
                exp_val     = {seg_ref[m_nib[idx]], ~m_dp[idx]};
            end else begin
                exp_en  = '1;
                exp_val = 8'hFF;
            end
        end
        w = int'(addr[3:1]);
        if (cs && re) exp_rd = model_read(w);
        if (cs && we) begin
            if (w < DIGITS / 4)
                for (int j = 0; j < 4; j++) m_nib[4*w + j] = wd[4*j +: 4];
            else if (w == 4) m_mask = wd[DIGITS-1:0];
            else if (w == 5) m_dp = wd[DIGITS-1:0];
            else if (w == 6) begin
                if (BLINK_EN) m_blink = wd[DIGITS-1:0];
            end
            else if (w == 7) m_ctrl = wd[0];
        end
    endtask

    task automatic bus_cycle(input bit cs, input bit we, input bit re,
                             input logic [3:0] addr, input logic [15:0] wd);
        digitalTubeCtrl = cs;
        write_enable    = we;
        read_enable     = re;
        address         = addr;
        write_data_in   = wd;
        @(posedge clock);
        model_edge(cs, we, re, addr, wd);
        #1;
        check("enable", 32'(enable), 32'(exp_en));
        check("value", 32'(value), 32'(exp_val));
        check("read_data_out", 32'(read_data_out), 32'(exp_rd));
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) bus_cycle(1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
    endtask

    task automatic random_cycles(input int cycles);
        bit cs, we, re;
        logic [3:0] a;
        logic [15:0] d;
        for (int i = 0; i < cycles; i++) begin
            cs = ($urandom_range(0, 3) != 0);
            we = ($urandom_range(0, 2) == 0);
            re = ($urandom_range(0, 1) == 0);
            a  = 4'($urandom_range(0, 15));
            d  = 16'($urandom);
            if (a[3:1] == 3'd7) d[0] = ($urandom_range(0, 3) == 0);
            bus_cycle(cs, we, re, a, d);
        end
    endtask

    task automatic mid_reset();
        digitalTubeCtrl = 1'b0;
        write_enable    = 1'b0;
        read_enable     = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_enable", 32'(enable), 32'(DIGITS'('1)));
        check("async_reset_value", 32'(value), 32'h0000_00FF);
        check("async_reset_rd", 32'(read_data_out), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        check("reset_enable", 32'(enable), 32'(DIGITS'('1)));
        check("reset_value", 32'(value), 32'h0000_00FF);
        check("reset_rd", 32'(read_data_out), 32'h0);
        reset = 1'b0;

        bus_cycle(1'b1, 1'b1, 1'b0, 4'h0, 16'h1234);
        bus_cycle(1'b1, 1'b1, 1'b0, 4'h8, 16'h000F);
        idle(CLK_DIV * DIGITS * 2);

        bus_cycle(1'b1, 1'b1, 1'b0, 4'hA, 16'h0001);
        bus_cycle(1'b1, 1'b0, 1'b1, 4'hA, 16'h0000);
        idle(CLK_DIV * DIGITS);

        bus_cycle(1'b1, 1'b1, 1'b0, 4'hE, 16'h0001);
        idle(CLK_DIV * 5);
        bus_cycle(1'b1, 1'b1, 1'b0, 4'hE, 16'h0000);
        idle(CLK_DIV * DIGITS);

        bus_cycle(1'b0, 1'b1, 1'b0, 4'h0, 16'hFFFF);
        bus_cycle(1'b1, 1'b0, 1'b1, 4'h0, 16'h0000);
        bus_cycle(1'b1, 1'b1, 1'b1, 4'h0, 16'hABCD);
        bus_cycle(1'b1, 1'b0, 1'b1, 4'hC, 16'h0000);
        bus_cycle(1'b1, 1'b1, 1'b0, 4'h6, 16'h5555);
        bus_cycle(1'b1, 1'b0, 1'b1, 4'h6, 16'h0000);

        bus_cycle(1'b1, 1'b1, 1'b0, 4'hC, 16'h0001);
        bus_cycle(1'b1, 1'b1, 1'b0, 4'h8, 16'h0001);
        idle(CLK_DIV * DIGITS * 6);

        random_cycles(1500);

        bus_cycle(1'b1, 1'b1, 1'b0, 4'h8, 16'hFFFF);
        bus_cycle(1'b1, 1'b1, 1'b0, 4'hE, 16'h0000);
        idle(CLK_DIV * 5 + 2);
        mid_reset();
        idle(CLK_DIV * 3);

        random_cycles(800);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
